// File: rtl/column_parallel_array_pkg.sv
// Shared defaults for the multi-column parallel activation buffer.
package column_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 6;
   localparam int NUM_COL    = 4;
   localparam int PTR_W      = ADDR_WIDTH + 1;

endpackage

// File: rtl/column_parallel_array_ctrl.sv
// Single column of the parallel array: circular RAM with write, read and
// base pointers. The base pointer marks the oldest word that may still be
// replayed, so space is only released when the reader commits.

// Simple dual-port RAM with a registered read port. The read register only
// loads on a read request, so the last word read stays on the output.
module ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_write_en,
   input  logic [ADDR_WIDTH-1:0] s_write_addr,
   input  logic [DATA_WIDTH-1:0] s_write_data,
   input  logic                  s_read_req,
   input  logic [ADDR_WIDTH-1:0] s_read_addr,
   output logic [DATA_WIDTH-1:0] s_read_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Storage array write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (s_write_en) begin
         mem[s_write_addr] <= s_write_data;
      end
   end

   // Registered read port, cleared on reset so the lane starts at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_read_data <= '0;
      end else if (s_read_req) begin
         s_read_data <= mem[s_read_addr];
      end
   end

endmodule

module column_ctrl
   import column_pkg::*;
#(
   parameter int DATA_WIDTH = column_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = column_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mode_i,
   input  logic                  wrReq_i,
   input  logic [DATA_WIDTH-1:0] wrData_i,
   input  logic                  rdEn_i,
   input  logic                  rdReq_i,
   input  logic                  rdRewind_i,
   input  logic                  rdCommit_i,
   output logic [DATA_WIDTH-1:0] rdData_o,
   output logic                  rdValid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  errOvf_o,
   output logic                  errUdf_o
);

   localparam int PtrW = ADDR_WIDTH + 1;
   localparam logic [PtrW-1:0] DepthP = PtrW'(2**ADDR_WIDTH);

   logic [PtrW-1:0]       wrPtr_q, wrPtr_d;
   logic [PtrW-1:0]       rdPtr_q, rdPtr_d;
   logic [PtrW-1:0]       basePtr_q, basePtr_d;
   logic                  rdValid_q;
   logic                  errOvf_q, errUdf_q;
   logic                  fullW, emptyW;
   logic                  wrFire, rdFire, udfHit;
   logic [DATA_WIDTH-1:0] ramData;

   // Flags, fire strobes and next-state pointers, all from pre-cycle pointers.
   always_comb begin
      fullW     = (wrPtr_q - basePtr_q) == DepthP;
      emptyW    = (rdPtr_q == wrPtr_q);
      wrFire    = wrReq_i & ~fullW;
      rdFire    = rdEn_i & rdReq_i & ~emptyW & ~rdRewind_i;
      udfHit    = rdEn_i & rdReq_i & emptyW & ~rdRewind_i;
      wrPtr_d   = wrFire ? (wrPtr_q + PtrW'(1)) : wrPtr_q;
      rdPtr_d   = rdPtr_q;
      basePtr_d = basePtr_q;
      if (rdRewind_i) begin
         rdPtr_d = basePtr_q;
      end else begin
         if (rdFire) begin
            rdPtr_d = rdPtr_q + PtrW'(1);
         end
         if (rdCommit_i) begin
            basePtr_d = rdPtr_q;
         end
      end
   end

   // Pointer, read-valid and sticky error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         basePtr_q <= '0;
         rdValid_q <= 1'b0;
         errOvf_q  <= 1'b0;
         errUdf_q  <= 1'b0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         basePtr_q <= basePtr_d;
         rdValid_q <= rdFire;
         errOvf_q  <= errOvf_q | (wrReq_i & fullW);
         errUdf_q  <= errUdf_q | udfHit;
      end
   end

   ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) uRam (
      .clk          (clk),
      .reset        (reset),
      .s_write_en   (wrFire),
      .s_write_addr (wrPtr_q[ADDR_WIDTH-1:0]),
      .s_write_data (wrData_i),
      .s_read_req   (rdFire),
      .s_read_addr  (rdPtr_q[ADDR_WIDTH-1:0]),
      .s_read_data  (ramData)
   );

   // Output lane: raw RAM register, or zero-gated by valid when mode is set.
   always_comb begin
      rdData_o = ramData;
      if (mode_i && !rdValid_q) begin
         rdData_o = '0;
      end
   end

   assign rdValid_o = rdValid_q;
   assign full_o    = fullW;
   assign empty_o   = emptyW;
   assign errOvf_o  = errOvf_q;
   assign errUdf_o  = errUdf_q;

endmodule

// File: rtl/column_parallel_array.sv
// Top of the multi-column activation buffer: NUM_COL independent columns
// sharing a clock, a global read enable and the output mode select.
module column_parallel_array
   import column_pkg::*;
#(
   parameter int DATA_WIDTH = column_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = column_pkg::ADDR_WIDTH,
   parameter int NUM_COL    = column_pkg::NUM_COL
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          mode,
   input  logic [NUM_COL-1:0]            wr_req,
   input  logic [NUM_COL*DATA_WIDTH-1:0] wr_data,
   input  logic                          rd_en,
   input  logic [NUM_COL-1:0]            rd_req,
   input  logic [NUM_COL-1:0]            rd_rewind,
   input  logic [NUM_COL-1:0]            rd_commit,
   output logic [NUM_COL*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_COL-1:0]            rd_valid,
   output logic [NUM_COL-1:0]            full,
   output logic [NUM_COL-1:0]            empty,
   output logic [NUM_COL-1:0]            err_ovf,
   output logic [NUM_COL-1:0]            err_udf
);

   for (genvar i = 0; i < NUM_COL; i++) begin : gCol
      column_ctrl #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) uCol (
         .clk        (clk),
         .reset      (reset),
         .mode_i     (mode),
         .wrReq_i    (wr_req[i]),
         .wrData_i   (wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .rdEn_i     (rd_en),
         .rdReq_i    (rd_req[i]),
         .rdRewind_i (rd_rewind[i]),
         .rdCommit_i (rd_commit[i]),
         .rdData_o   (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .rdValid_o  (rd_valid[i]),
         .full_o     (full[i]),
         .empty_o    (empty[i]),
         .errOvf_o   (err_ovf[i]),
         .errUdf_o   (err_udf[i])
      );
   end

endmodule

// File: tb/tb_column_parallel_array.sv
// Directed bench for column_parallel_array with hand-computed expectations.
module tb_column_parallel_array;

   logic        clk;
   logic        reset;
   logic        mode;
   logic [3:0]  wr_req;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [3:0]  rd_req;
   logic [3:0]  rd_rewind;
   logic [3:0]  rd_commit;
   logic [31:0] rd_data;
   logic [3:0]  rd_valid;
   logic [3:0]  full;
   logic [3:0]  empty;
   logic [3:0]  err_ovf;
   logic [3:0]  err_udf;

   int testsRun;
   int testsFailed;

   column_parallel_array dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .wr_req    (wr_req),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_req    (rd_req),
      .rd_rewind (rd_rewind),
      .rd_commit (rd_commit),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .full      (full),
      .empty     (empty),
      .err_ovf   (err_ovf),
      .err_udf   (err_udf)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Whole-run watchdog so a stuck simulation still ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int col, input logic [7:0] d);
      wr_req = 4'b0001 << col;
      wr_data = '0;
      wr_data[col*8 +: 8] = d;
      tick();
      wr_req = '0;
   endtask

   task automatic readWord(input int col, input logic [7:0] expected, input string tag);
      logic [31:0] sh;
      rd_en = 1'b1;
      rd_req = 4'b0001 << col;
      tick();
      rd_req = '0;
      sh = rd_data >> (col*8);
      checkOutput(tag, {24'h0, sh[7:0]}, {24'h0, expected});
      checkOutput({tag, "_valid"}, {28'h0, rd_valid}, {28'h0, 4'b0001 << col});
   endtask

   initial begin
      testsRun = 0;
      testsFailed = 0;
      reset = 1'b1;
      mode = 1'b0;
      wr_req = '0;
      wr_data = '0;
      rd_en = 1'b0;
      rd_req = '0;
      rd_rewind = '0;
      rd_commit = '0;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("rst_valid", {28'h0, rd_valid}, 32'h0);
      checkOutput("rst_empty", {28'h0, empty}, 32'hF);
      checkOutput("rst_full", {28'h0, full}, 32'h0);
      checkOutput("rst_err", {24'h0, err_ovf, err_udf}, 32'h0);
      checkOutput("rst_data", rd_data, 32'h0);

      // Column 0: three writes, three back-to-back reads.
      applyStimulus(0, 8'h11);
      applyStimulus(0, 8'h22);
      applyStimulus(0, 8'h33);
      checkOutput("c0_notempty", {28'h0, empty}, 32'hE);
      readWord(0, 8'h11, "c0_rd0");
      readWord(0, 8'h22, "c0_rd1");
      readWord(0, 8'h33, "c0_rd2");
      checkOutput("c0_empty_after", {28'h0, empty}, 32'hF);

      // Column 1: fill, overflow attempt, drain, underflow attempt.
      for (int i = 0; i < 64; i++) applyStimulus(1, 8'h40 + 8'(i));
      checkOutput("c1_full", {28'h0, full}, 32'h2);
      applyStimulus(1, 8'hFF);
      checkOutput("c1_ovf", {28'h0, err_ovf}, 32'h2);
      checkOutput("c1_full_kept", {28'h0, full}, 32'h2);
      for (int i = 0; i < 64; i++) readWord(1, 8'h40 + 8'(i), $sformatf("c1_rd%0d", i));
      checkOutput("c1_empty", {28'h0, empty}, 32'hF);
      rd_en = 1'b1;
      rd_req = 4'b0010;
      tick();
      rd_req = '0;
      checkOutput("c1_udf", {28'h0, err_udf}, 32'h2);
      checkOutput("c1_udf_novalid", {28'h0, rd_valid}, 32'h0);

      // Column 2: replay via rewind, then commit and refill exactly.
      for (int i = 0; i < 4; i++) applyStimulus(2, 8'hA0 + 8'(i));
      readWord(2, 8'hA0, "c2_rd0");
      readWord(2, 8'hA1, "c2_rd1");
      rd_rewind = 4'b0100;
      rd_req = 4'b0100;
      tick();
      rd_rewind = '0;
      rd_req = '0;
      checkOutput("c2_rewind_noread", {28'h0, rd_valid}, 32'h0);
      for (int i = 0; i < 4; i++) readWord(2, 8'hA0 + 8'(i), $sformatf("c2_replay%0d", i));
      rd_commit = 4'b0100;
      tick();
      rd_commit = '0;
      for (int i = 0; i < 63; i++) applyStimulus(2, 8'hC0 + 8'(i));
      checkOutput("c2_not_early_full", {28'h0, full}, 32'h2);
      applyStimulus(2, 8'hFF);
      checkOutput("c2_full_exact", {28'h0, full}, 32'h6);

      // Output mode gating and stalled reads.
      mode = 1'b1;
      tick();
      checkOutput("mode1_zero", rd_data, 32'h0);
      mode = 1'b0;
      #1;
      checkOutput("mode0_hold", rd_data, 32'h00A37F33);
      rd_en = 1'b0;
      rd_req = 4'hF;
      tick();
      rd_req = '0;
      checkOutput("stall_novalid", {28'h0, rd_valid}, 32'h0);
      checkOutput("stall_noerr", {28'h0, err_udf}, 32'h2);
      mode = 1'b1;
      readWord(2, 8'hC0, "stall_noadvance");
      tick();
      checkOutput("mode1_gate_after", rd_data, 32'h0);
      mode = 1'b0;

      // Column 3: rewind beats commit, then same-cycle write and read.
      applyStimulus(3, 8'hD0);
      applyStimulus(3, 8'hD1);
      readWord(3, 8'hD0, "c3_rd0");
      rd_rewind = 4'b1000;
      rd_commit = 4'b1000;
      tick();
      rd_rewind = '0;
      rd_commit = '0;
      readWord(3, 8'hD0, "c3_rewound");
      for (int i = 0; i < 62; i++) applyStimulus(3, 8'h80 + 8'(i));
      checkOutput("c3_base_kept", {28'h0, full}, 32'hE);
      readWord(3, 8'hD1, "c3_rd1");
      for (int i = 0; i < 61; i++) readWord(3, 8'h80 + 8'(i), $sformatf("c3_rd_%0d", i));
      rd_commit = 4'b1000;
      tick();
      rd_commit = '0;
      wr_req = 4'b1000;
      wr_data = 32'hEE000000;
      rd_en = 1'b1;
      rd_req = 4'b1000;
      tick();
      wr_req = '0;
      rd_req = '0;
      checkOutput("c3_wr_rd_old", {24'h0, rd_data[31:24]}, 32'hBD);
      checkOutput("c3_occ_one", {31'h0, empty[3]}, 32'h0);
      checkOutput("c3_no_ovf", {28'h0, err_ovf}, 32'h2);
      readWord(3, 8'hEE, "c3_rd_new");
      checkOutput("c3_empty_end", {31'h0, empty[3]}, 32'h1);

      // Reset shortly after a read fires.
      applyStimulus(0, 8'h55);
      rd_en = 1'b1;
      rd_req = 4'b0001;
      tick();
      rd_req = '0;
      checkOutput("pre_rst_valid", {28'h0, rd_valid}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("mid_rst_valid", {28'h0, rd_valid}, 32'h0);
      checkOutput("mid_rst_data", rd_data, 32'h0);
      checkOutput("mid_rst_empty", {28'h0, empty}, 32'hF);
      checkOutput("mid_rst_full", {28'h0, full}, 32'h0);
      checkOutput("mid_rst_err", {24'h0, err_ovf, err_udf}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/column_parallel_array.md
Name: column_parallel_array

Overview:
- Multi-column successor to the single-column parallel buffer: NUM_COL independent circular RAM columns sharing one clock.
- Each column has its own write pointer, read pointer, full/empty flags and a read-reuse window (mark/rewind). CNN row data can be replayed for several kernel passes before space is released.
- Sits between the input-activation loader (writer) and the PE-array column feeds (reader).

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 6, log2 of words per column; depth = 2**ADDR_WIDTH.
- NUM_COL, 4, number of independent columns.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = raw RAM output, 1 = output zero-gated by rd_valid.
- wr_req  in  NUM_COL  per-column write strobe.
- wr_data  in  NUM_COL*DATA_WIDTH  column i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_en  in  1  global read enable (stall when 0).
- rd_req  in  NUM_COL  per-column read request.
- rd_rewind  in  NUM_COL  reload read pointer from the column's base pointer.
- rd_commit  in  NUM_COL  release consumed words: base pointer takes read pointer.
- rd_data  out  NUM_COL*DATA_WIDTH  read data, packed like wr_data.
- rd_valid  out  NUM_COL  rd_data lane valid.
- full  out  NUM_COL  column cannot accept a write.
- empty  out  NUM_COL  no unread word at the read pointer.
- err_ovf  out  NUM_COL  sticky: write attempted while full.
- err_udf  out  NUM_COL  sticky: read attempted while empty.

Behaviour:
- Per column i, registers: wr_ptr, rd_ptr, base_ptr, each ADDR_WIDTH+1 bits (extra wrap bit). The low ADDR_WIDTH bits address the RAM.
- full[i] = (wr_ptr - base_ptr) == 2**ADDR_WIDTH. empty[i] = (rd_ptr == wr_ptr). Both combinational from the registers.
- wr_fire = wr_req & ~full. On wr_fire: write wr_data lane at wr_ptr, then wr_ptr+1, wrapping naturally modulo 2**(ADDR_WIDTH+1).
- wr_req while full: write dropped, pointers unchanged, err_ovf set.
- rd_fire = rd_en & rd_req & ~empty & ~rd_rewind. On rd_fire: RAM read issued at rd_ptr, then rd_ptr+1.
- rd_en & rd_req & empty & ~rd_rewind: no read, err_udf set.
- rd_req while rd_en=0: no effect, no error.
- Read latency is 1 cycle: rd_valid[i] is rd_fire registered, and the rd_data lane holds the RAM registered output in that same cycle.
- mode=0: rd_data is the RAM output whatever rd_valid is; the last read word is held.
- mode=1: a lane reads 0 whenever its rd_valid=0.
- mode may change at any time; the effect is combinational on rd_data.
- rd_rewind[i]: rd_ptr takes base_ptr next cycle and overrides a same-cycle read. It does not affect rd_valid of a read already in flight.
- rd_commit[i]: base_ptr takes the current rd_ptr value (pre-increment), freeing space. If rd_rewind and rd_commit coincide, rewind wins and commit is ignored.
- Read/write address collision cannot occur: a read needs rd_ptr != wr_ptr.
- A write to a slot below base_ptr cannot occur: a write needs not-full. Committed reuse is therefore safe.
- Simultaneous write and read on one column are both allowed. full and empty are evaluated on pre-cycle pointers.
- Reset values: all pointers 0, rd_valid 0, err_* 0, empty all 1, full all 0, rd_data 0 (RAM output register cleared). RAM contents are not reset.
- Reset mid-operation aborts in-flight reads; rd_valid=0 on the next cycle.

Decomposition:
- Shared package: column_pkg holding defaults DATA_WIDTH, ADDR_WIDTH, NUM_COL and a pointer-width constant PTR_W = ADDR_WIDTH+1.
- One sub-module: column_ctrl. It holds the pointers, flags, errors and the RAM instance for a single column, and is instantiated NUM_COL times by a generate loop.
- RAM: the existing ram block (1 write port, 1 read port, registered read with s_read_req).

Test Plan:
- Reset, then write 0x11,0x22,0x33 to column 0, then rd_req[0]=1 with rd_en=1 for 3 cycles -> rd_data lane0 = 0x11,0x22,0x33 on the 3 cycles after the first request, rd_valid[0]=1 each cycle, empty[0]=1 afterwards; the other columns stay empty with rd_valid=0.
- Write 64 words to column 1 (ADDR_WIDTH=6) -> full[1]=1. A 65th write is dropped and err_ovf[1]=1. Read all 64 -> data matches in order, and err_udf[1] is set on the next request.
- Column 2: write 4 words, read 2, assert rd_rewind, read 4 -> sequence w0,w1,w0,w1,w2,w3. Then rd_commit; writing 64 more words fills exactly (no early full).
- mode=1 with rd_req=0 -> rd_data all zeros. Switch to mode=0 -> the lane shows the last read word. With rd_en=0 and rd_req=1 -> no pointer movement, no error.
- Same-cycle rd_rewind and rd_commit on column 3 -> base_ptr unchanged and rd_ptr = base_ptr. Then write and read on the same cycle while occupancy is 1 -> the read returns the old word, and occupancy stays 1.
- Reset asserted one cycle after rd_fire -> rd_valid=0, rd_data=0, and all flags at reset values on the next cycle.
